multicycle_control: RTL

Main control state machine for the multi-cycle MIPS processor. It sequences the shared datapath (PC, memory, IR, register file, ALU) through fetch, decode, execute, memory and write-back steps, one state per clock. It drives the PC update (`pc_src`, PC write enable) and every datapath mux and enable from the instruction opcode and the ALU zero flag.

---
 rtl/mips_pkg.sv | 61 ++++++
 rtl/control_decode.sv | 69 ++++++
 rtl/multicycle_control.sv | 86 ++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared encodings for the multi-cycle MIPS control path: opcodes, FSM states,
// datapath mux codes and the bundle of control outputs.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_EXECUTE   = 4'd6,
        S_R_WB      = 4'd7,
        S_BRANCH    = 4'd8,
        S_JUMP      = 4'd9,
        S_ADDI_EXEC = 4'd10,
        S_ADDI_WB   = 4'd11
    } state_e;

    localparam logic [1:0] PC_SRC_ALU    = 2'b00;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

    localparam logic [1:0] ALU_OP_ADD   = 2'b00;
    localparam logic [1:0] ALU_OP_SUB   = 2'b01;
    localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

    localparam logic [1:0] SRC_B_REG     = 2'b00;
    localparam logic [1:0] SRC_B_FOUR    = 2'b01;
    localparam logic [1:0] SRC_B_IMM     = 2'b10;
    localparam logic [1:0] SRC_B_IMM_SH2 = 2'b11;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic [1:0] pc_src;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
    } ctrl_t;

    function automatic logic op_supported(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
               (op == OP_BEQ) || (op == OP_J) || (op == OP_ADDI);
    endfunction

endpackage

// File: rtl/control_decode.sv
// Moore output decode: maps the current FSM state to datapath controls.
module control_decode
    import mips_pkg::*;
(
    input  state_e state_i,
    output ctrl_t  ctrl_o
);

    always_comb begin
        ctrl_o = '0;
        unique case (state_i)
            S_FETCH: begin
                ctrl_o.mem_read  = 1'b1;
                ctrl_o.ir_write  = 1'b1;
                ctrl_o.alu_src_b = SRC_B_FOUR;
                ctrl_o.alu_op    = ALU_OP_ADD;
                ctrl_o.pc_write  = 1'b1;
                ctrl_o.pc_src    = PC_SRC_ALU;
            end
            // Branch target is precomputed here so BRANCH can load it from ALU_out.
            S_DECODE: begin
                ctrl_o.alu_src_b = SRC_B_IMM_SH2;
                ctrl_o.alu_op    = ALU_OP_ADD;
            end
            S_MEM_ADDR, S_ADDI_EXEC: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRC_B_IMM;
                ctrl_o.alu_op    = ALU_OP_ADD;
            end
            S_MEM_READ: begin
                ctrl_o.mem_read = 1'b1;
                ctrl_o.i_or_d   = 1'b1;
            end
            S_MEM_WB: begin
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.mem_to_reg = 1'b1;
            end
            S_MEM_WRITE: begin
                ctrl_o.mem_write = 1'b1;
                ctrl_o.i_or_d    = 1'b1;
            end
            S_EXECUTE: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRC_B_REG;
                ctrl_o.alu_op    = ALU_OP_FUNCT;
            end
            S_R_WB: begin
                ctrl_o.reg_write = 1'b1;
                ctrl_o.reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                ctrl_o.alu_src_a     = 1'b1;
                ctrl_o.alu_src_b     = SRC_B_REG;
                ctrl_o.alu_op        = ALU_OP_SUB;
                ctrl_o.pc_write_cond = 1'b1;
                ctrl_o.pc_src        = PC_SRC_ALUOUT;
            end
            S_JUMP: begin
                ctrl_o.pc_write = 1'b1;
                ctrl_o.pc_src   = PC_SRC_JUMP;
            end
            S_ADDI_WB: begin
                ctrl_o.reg_write = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM of the multi-cycle MIPS: state register, next-state logic,
// PC write gating and illegal-opcode detection.
module multicycle_control
    import mips_pkg::*;
#(
    parameter int OP_W = 6
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [OP_W-1:0] opcode,
    input  logic            zero,
    output logic            pc_en,
    output logic [1:0]      pc_src,
    output logic            i_or_d,
    output logic            mem_read,
    output logic            mem_write,
    output logic            ir_write,
    output logic            reg_write,
    output logic            mem_to_reg,
    output logic            reg_dst,
    output logic            alu_src_a,
    output logic [1:0]      alu_src_b,
    output logic [1:0]      alu_op,
    output logic            illegal_op,
    output logic [3:0]      state_dbg
);

    state_e     state_q, state_d;
    ctrl_t      ctrl_raw, ctrl;
    logic [5:0] op;

    assign op = 6'(opcode);

    always_ff @(posedge clk) begin
        if (reset) state_q <= S_FETCH;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = S_FETCH;
        unique case (state_q)
            S_FETCH: state_d = S_DECODE;
            S_DECODE: begin
                unique case (op)
                    OP_LW, OP_SW: state_d = S_MEM_ADDR;
                    OP_RTYPE:     state_d = S_EXECUTE;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
                    OP_ADDI:      state_d = S_ADDI_EXEC;
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEM_ADDR:  state_d = (op == OP_LW) ? S_MEM_READ
                                 : (op == OP_SW) ? S_MEM_WRITE : S_FETCH;
            S_MEM_READ:  state_d = S_MEM_WB;
            S_EXECUTE:   state_d = S_R_WB;
            S_ADDI_EXEC: state_d = S_ADDI_WB;
            // Terminal states and the unused encodings 12-15 all return to FETCH.
            default:     state_d = S_FETCH;
        endcase
    end

    control_decode u_decode (
        .state_i (state_q),
        .ctrl_o  (ctrl_raw)
    );

    // Reset silences every control so a mid-instruction reset cannot write state.
    assign ctrl = reset ? '0 : ctrl_raw;

    assign pc_en      = ctrl.pc_write | (ctrl.pc_write_cond & zero);
    assign pc_src     = ctrl.pc_src;
    assign i_or_d     = ctrl.i_or_d;
    assign mem_read   = ctrl.mem_read;
    assign mem_write  = ctrl.mem_write;
    assign ir_write   = ctrl.ir_write;
    assign reg_write  = ctrl.reg_write;
    assign mem_to_reg = ctrl.mem_to_reg;
    assign reg_dst    = ctrl.reg_dst;
    assign alu_src_a  = ctrl.alu_src_a;
    assign alu_src_b  = ctrl.alu_src_b;
    assign alu_op     = ctrl.alu_op;
    assign illegal_op = ~reset & (state_q == S_DECODE) & ~op_supported(op);
    assign state_dbg  = state_q;

endmodule
